// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO read-side packer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_pkg;

  localparam int FIFO_DATA_W  = 8;
  localparam int FIFO_DEPTH   = 16;
  localparam int PACK_TIMEOUT = 16;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_t;

endpackage

// File: rtl/fifo_word_packer_if.sv
// Byte-side FIFO pop port plus word-side valid/ready stream of the packer.
// Latency: n/a (wires only).
// Backpressure: m_ready from the slave side throttles the master.
interface fifo_word_packer_if #(
  parameter int BYTES_PER_WORD = 4
);
  import fifo_pkg::*;

  logic                        fifo_empty;
  logic [FIFO_DATA_W-1:0]      fifo_data;
  logic                        fifo_rd;
  logic                        m_valid;
  logic                        m_ready;
  logic [8*BYTES_PER_WORD-1:0] m_data;
  logic [BYTES_PER_WORD-1:0]   m_keep;

  // Packer side: consumes FIFO bytes, produces words.
  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_rd, m_valid, m_data, m_keep
  );

  // Environment side: supplies FIFO bytes, consumes words.
  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_rd, m_valid, m_data, m_keep
  );

endinterface

// File: rtl/pack_idle_timer.sv
// Saturating idle counter for a partially filled word.
// Latency: count updates on the edge after clear/inc; expire_now flags the cycle whose edge reaches TIMEOUT.
// Backpressure: none; caller gates inc.
module pack_idle_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired,
  output logic expire_now
);

  localparam logic [7:0] LIMIT    = 8'(TIMEOUT);
  localparam logic [7:0] LIMIT_M1 = 8'(TIMEOUT - 1);

  logic [7:0] count;

  // Count idle cycles; clear wins over inc, saturate at 0xFF.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (inc && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

  // expire_now lets the FSM leave FILL on the very edge the count hits TIMEOUT,
  // so the word appears exactly TIMEOUT cycles after the last pop.
  assign expired    = (count == LIMIT);
  assign expire_now = inc && (count == LIMIT_M1);

endmodule

// File: rtl/fifo_word_packer.sv
// Pops bytes from fifo_mem and packs them little-endian into words with a lane keep mask.
// Latency: m_valid rises on the edge that pops the last lane (or flush/timeout edge).
// Backpressure: while a word is held and m_ready=0, no further bytes are popped.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter int TIMEOUT        = PACK_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  fifo_word_packer_if.master  pif,
  output logic [15:0]         word_count
);

  localparam int LANE_W = $clog2(BYTES_PER_WORD);
  localparam int WORD_W = 8 * BYTES_PER_WORD;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

  pack_state_t               state, state_nxt;
  logic [LANE_W-1:0]         byte_cnt, byte_cnt_nxt;
  logic [WORD_W-1:0]         data_q, data_nxt;
  logic [BYTES_PER_WORD-1:0] keep_q, keep_nxt;

  logic pop;
  logic pending;
  logic last_lane;
  logic accept;
  logic timer_clear;
  logic timer_inc;
  logic expired;
  logic expire_now;
  logic timeout_hit;

  // Never pops while empty, while holding a word, or while in reset.
  assign pop       = (state == FILL) && !pif.fifo_empty && rst_n;
  assign pending   = (byte_cnt != '0);
  assign last_lane = (byte_cnt == LAST_LANE);
  assign accept    = (state == HOLD) && pif.m_ready;

  assign timer_clear = pop || (state == HOLD);
  assign timer_inc   = (state == FILL) && pending && !pop;
  assign timeout_hit = expire_now || expired;

  pack_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (timer_clear),
    .inc        (timer_inc),
    .expired    (expired),
    .expire_now (expire_now)
  );

  // Next-state, lane write decode and word release.
  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    data_nxt     = data_q;
    keep_nxt     = keep_q;
    unique case (state)
      FILL: begin
        if (pop) begin
          data_nxt[{byte_cnt, 3'b000} +: 8] = pif.fifo_data;
          keep_nxt[byte_cnt]                = 1'b1;
          byte_cnt_nxt                      = byte_cnt + 1'b1;
        end
        // A byte popped alongside flush is part of the emitted word; flush
        // and timeout together still yield one emission.
        if ((pop && last_lane) ||
            (flush && (pending || pop)) ||
            (pending && !pop && timeout_hit)) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (pif.m_ready) begin
          state_nxt    = FILL;
          byte_cnt_nxt = '0;
          data_nxt     = '0;
          keep_nxt     = '0;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // State and word assembly registers; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= FILL;
      byte_cnt <= '0;
      data_q   <= '0;
      keep_q   <= '0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      data_q   <= data_nxt;
      keep_q   <= keep_nxt;
    end
  end

  // Count accepted words, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_count <= 16'd0;
    end else if (accept) begin
      word_count <= word_count + 16'd1;
    end
  end

  assign pif.fifo_rd = pop;
  assign pif.m_valid = (state == HOLD);
  assign pif.m_data  = data_q;
  assign pif.m_keep  = keep_q;

endmodule

// File: doc/fifo_word_packer.md
# fifo_word_packer

Read-side drain stage that sits directly downstream of `fifo_mem`. It pops bytes from the circular FIFO whenever the FIFO is non-empty and packs them little-endian into 32-bit words. Words leave on a valid/ready stream. Partial words are emitted on an explicit flush or after a programmable idle timeout, with a byte-lane keep mask.

## Interface
Parameters:
- `BYTES_PER_WORD`, 4: bytes per output word; output width is `8*BYTES_PER_WORD`.
- `TIMEOUT`, 16: idle cycles with a partial word before forced emission; legal range 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low, sampled on the `clk` rising edge.
- `fifo_empty`  in  1  from `fifo_mem`.
- `fifo_data`  in  8  from `fifo_mem` `data_out`; the head byte, valid while `fifo_empty`=0.
- `fifo_rd`  out  1  to `fifo_mem` `rd`; a high level at a rising edge pops one byte.
- `flush`  in  1  one-cycle request to emit any partial word.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  32  packed word; first popped byte is in `[7:0]`.
- `m_keep`  out  4  lane-valid mask; bit n covers `m_data[8n+7:8n]`.
- `word_count`  out  16  count of accepted words (`m_valid & m_ready`); wraps at 0xFFFF.

## Operation
The block is a two-state FSM: FILL and HOLD. Reset state is FILL.

FILL:
- `fifo_rd` = `!fifo_empty & rst_n`. It is never asserted while empty, so `fifo_underflow` is never caused by this block.
- On a pop, `fifo_data` is written to lane `byte_cnt`, the lane's keep bit is set, `byte_cnt` increments, and the idle counter clears.
- When the pop fills lane `BYTES_PER_WORD-1`, the FSM moves to HOLD with `m_keep`=all ones.
- While `byte_cnt`>0 and no pop occurs, the idle counter increments. When it reaches `TIMEOUT`, the FSM moves to HOLD with the partial word.
- `flush` with `byte_cnt`>0, or with a pop in the same cycle, moves the FSM to HOLD. A byte popped in that cycle is included in the emitted word.
- `flush` with `byte_cnt`=0 and no pop is ignored. Flush and timeout in the same cycle produce a single emission.
- Unused lanes of a partial word are 0.

HOLD:
- `m_valid`=1 and `fifo_rd`=0. `m_data` and `m_keep` are stable until accepted.
- On `m_valid & m_ready`, `word_count` increments. Next cycle the FSM is in FILL with `byte_cnt`=0, keep=0, data=0 and idle counter=0.
- `flush` is ignored in HOLD.

Back-pressure: while `m_ready`=0 the block stops popping. `fifo_mem` fills and asserts `fifo_full` and `fifo_threshold` normally.

Width rules:
- `byte_cnt` is 2 bits.
- The idle counter is 8 bits and saturates.
- `word_count` is 16 bits and wraps.

## Timing
- Reset: with `rst_n`=0 at an edge, on the next cycle the FSM is in FILL and `m_valid`=0, `m_data`=0, `m_keep`=0, `word_count`=0, `byte_cnt`=0 and the idle counter is 0. `fifo_rd` is 0 combinationally while `rst_n`=0.
- Reset mid-word or in HOLD discards the held bytes. Bytes already popped are lost.
- Latency: the edge that pops the last lane is the same edge at which `m_valid` rises. `m_valid` is therefore visible one cycle after the final `fifo_rd` cycle.
- Throughput: with a continuously non-empty FIFO and `m_ready`=1, one word per `BYTES_PER_WORD`+1 cycles.
- Timeout: `m_valid` rises exactly `TIMEOUT` cycles after the last pop of a partial word, provided no flush occurs.
- `m_valid` never drops without acceptance.

## Structure
- Package `fifo_pkg` holds:
  - `FIFO_DATA_W`=8, `FIFO_DEPTH`=16.
  - FSM state enum `pack_state_t` {FILL, HOLD}.
  - Default `PACK_TIMEOUT`=16.
- Sub-module `pack_idle_timer`: 8-bit saturating counter with `clear`/`inc` inputs and `expired` = (count == `TIMEOUT`) output.
- Top level contains the FSM, lane write decode and word counter.

## Test plan
- Reset, then write 0x01..0x04 into `fifo_mem` with `m_ready`=1. Required: one word `m_data`=0x04030201, `m_keep`=0xF, `word_count`=1.
- Write 17 bytes 0x01..0x11, one every 5 cycles. Required:
  - words 0x04030201, 0x08070605, 0x0C0B0A09 and 0x100F0E0D, each with `m_keep`=0xF;
  - then, 16 cycles after the last pop, 0x00000011 with `m_keep`=0x1;
  - `fifo_underflow` stays 0 throughout.
- Hold `m_ready`=0 and write 20 bytes. Required:
  - the first word is held stable in HOLD;
  - `fifo_rd` stays 0 after the fourth pop;
  - `fifo_full` asserts and further writes raise `fifo_overflow`;
  - releasing `m_ready` drains 4 full words (16 bytes) in order.
- Pop 0xAA and 0xBB, then pulse `flush` on the cycle 0xCC is popped. Required: `m_data`=0x00CCBBAA, `m_keep`=0x7. A later `flush` with no bytes pending yields no word.
- Assert `rst_n`=0 for one cycle after 2 bytes are packed, then write 0x55..0x58. Required: `m_valid` low the cycle after reset, and the next word is 0x58575655 with keep 0xF and `word_count`=1.
